// File: rtl/store_pkg.sv
// Shared store-path definitions: access size and FSM state encodings plus
// size-to-byte-mask helpers used by the store split unit and lane generator.
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // One bit per byte written by an access of the given size, right-aligned.
  function automatic logic [7:0] size_bytemask(input size_e size);
    case (size)
      SIZE_B:  size_bytemask = 8'h01;
      SIZE_H:  size_bytemask = 8'h03;
      SIZE_W:  size_bytemask = 8'h0F;
      default: size_bytemask = 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_mask(input size_e size);
    case (size)
      SIZE_B:  size_align_mask = 3'b000;
      SIZE_H:  size_align_mask = 3'b001;
      SIZE_W:  size_align_mask = 3'b011;
      default: size_align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Builds the double-width lane and strobe images for a store: size-masked
// data and byte strobes shifted to the byte offset within the bus word.
module store_lane_gen
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  size_e                      size,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            wdata,
  output logic [2*XLEN-1:0]          lane,
  output logic [2*(XLEN/8)-1:0]      strb
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] data_mask;

  // The upper half of each image is what spills into the second bus beat.
  always_comb begin
    bmask     = NB'(size_bytemask(size));
    data_mask = '0;
    for (int i = 0; i < NB; i++) begin
      data_mask[8*i +: 8] = {8{bmask[i]}};
    end
    lane = {{XLEN{1'b0}}, wdata & data_mask} << {offset, 3'b000};
    strb = {{NB{1'b0}}, bmask} << offset;
  end

endmodule

// File: rtl/store_split_unit.sv
// Store request to bus-beat converter: splits misaligned stores that cross a
// bus word into two beats, or faults them, and reports a one-cycle response.
module store_split_unit
  import store_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_funct3,
  input  logic                req_amo,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic                resp_valid,
  output logic                resp_fault,
  output logic                resp_split
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  state_e          state;
  size_e           size_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            fault_q;
  logic            split_q;

  size_e           req_size;
  logic            req_illegal;
  logic            req_misaligned;
  logic            req_fault;
  logic            accept;
  logic            unused_funct3_hi;

  logic [2*XLEN-1:0] lane;
  logic [2*NB-1:0]   strb;
  logic [XLEN-1:0]   beat0_addr;
  logic [XLEN-1:0]   beat1_addr;

  assign unused_funct3_hi = req_funct3[2];
  assign accept           = req_valid && req_ready;

  // AMOs ignore the funct3 width except to select doubleword on RV64.
  always_comb begin
    if (req_amo) begin
      req_size = (XLEN == 64 && req_funct3[1:0] == 2'b11) ? SIZE_D : SIZE_W;
    end else begin
      req_size = size_e'(req_funct3[1:0]);
    end
    req_illegal    = (req_size == SIZE_D) && (XLEN == 32);
    req_misaligned = |(req_addr[2:0] & size_align_mask(req_size));
    req_fault      = req_illegal || (req_misaligned && (req_amo || !ALLOW_SPLIT));
  end

  store_lane_gen #(
    .XLEN(XLEN)
  ) u_lane_gen (
    .size   (size_q),
    .offset (addr_q[OW-1:0]),
    .wdata  (wdata_q),
    .lane   (lane),
    .strb   (strb)
  );

  assign beat0_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  assign beat1_addr = beat0_addr + XLEN'(NB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      size_q  <= SIZE_B;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      split_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= req_fault;
            split_q <= 1'b0;
            state   <= req_fault ? ST_RESP : ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
            if (|strb[2*NB-1:NB]) begin
              split_q <= 1'b1;
              state   <= ST_BEAT1;
            end else begin
              state   <= ST_RESP;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            state <= ST_RESP;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are quiet during reset so an abandoned beat never looks live.
  always_comb begin
    req_ready  = !rst && (state == ST_IDLE);
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    resp_split = 1'b0;
    if (!rst) begin
      case (state)
        ST_BEAT0: begin
          mem_valid = 1'b1;
          mem_addr  = beat0_addr;
          mem_wdata = lane[XLEN-1:0];
          mem_wstrb = strb[NB-1:0];
        end
        ST_BEAT1: begin
          mem_valid = 1'b1;
          mem_addr  = beat1_addr;
          mem_wdata = lane[2*XLEN-1:XLEN];
          mem_wstrb = strb[2*NB-1:NB];
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_fault = fault_q;
          resp_split = split_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_split_unit.sv
// Self-checking bench for store_split_unit: three configurations (RV32 split,
// RV32 no-split, RV64 split) checked against a byte-level reference model.
module tb_store_split_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        req_valid;
  logic        req_amo;
  logic        mem_ready;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        a_req_ready, a_mem_valid, a_resp_valid, a_resp_fault, a_resp_split;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        n_req_ready, n_mem_valid, n_resp_valid, n_resp_fault, n_resp_split;
  logic [31:0] n_mem_addr, n_mem_wdata;
  logic [3:0]  n_mem_wstrb;
  logic        d_req_ready, d_mem_valid, d_resp_valid, d_resp_fault, d_resp_split;
  logic [63:0] d_mem_addr, d_mem_wdata;
  logic [7:0]  d_mem_wstrb;

  logic        o_req_ready, o_mem_valid, o_resp_valid, o_resp_fault, o_resp_split;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_addr [2];
  logic [63:0] exp_wdata[2];
  logic [7:0]  exp_wstrb[2];
  int          exp_beats;
  logic        exp_fault;

  logic [63:0] obs_addr [2];
  logic [63:0] obs_wdata[2];
  logic [7:0]  obs_wstrb[2];
  logic        obs_fault, obs_split;
  int          obs_resp_cyc;
  int          first_valid_cyc;

  store_split_unit #(.XLEN(32), .ALLOW_SPLIT(1'b1)) dut_split32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 0)), .req_ready(a_req_ready),
    .req_funct3(req_funct3), .req_amo(req_amo), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[31:0]), .mem_valid(a_mem_valid), .mem_ready(mem_ready),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .resp_valid(a_resp_valid), .resp_fault(a_resp_fault), .resp_split(a_resp_split)
  );

  store_split_unit #(.XLEN(32), .ALLOW_SPLIT(1'b0)) dut_nosplit32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 1)), .req_ready(n_req_ready),
    .req_funct3(req_funct3), .req_amo(req_amo), .req_addr(req_addr[31:0]),
    .req_wdata(req_wdata[31:0]), .mem_valid(n_mem_valid), .mem_ready(mem_ready),
    .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_wstrb(n_mem_wstrb),
    .resp_valid(n_resp_valid), .resp_fault(n_resp_fault), .resp_split(n_resp_split)
  );

  store_split_unit #(.XLEN(64), .ALLOW_SPLIT(1'b1)) dut_split64 (
    .clk(clk), .rst(rst), .req_valid(req_valid && (sel == 2)), .req_ready(d_req_ready),
    .req_funct3(req_funct3), .req_amo(req_amo), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_valid(d_mem_valid), .mem_ready(mem_ready),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_wstrb(d_mem_wstrb),
    .resp_valid(d_resp_valid), .resp_fault(d_resp_fault), .resp_split(d_resp_split)
  );

  // Present the selected instance's outputs zero-extended to 64 bits.
  always_comb begin
    o_req_ready  = a_req_ready;
    o_mem_valid  = a_mem_valid;
    o_mem_addr   = {32'b0, a_mem_addr};
    o_mem_wdata  = {32'b0, a_mem_wdata};
    o_mem_wstrb  = {4'b0, a_mem_wstrb};
    o_resp_valid = a_resp_valid;
    o_resp_fault = a_resp_fault;
    o_resp_split = a_resp_split;
    if (sel == 1) begin
      o_req_ready  = n_req_ready;
      o_mem_valid  = n_mem_valid;
      o_mem_addr   = {32'b0, n_mem_addr};
      o_mem_wdata  = {32'b0, n_mem_wdata};
      o_mem_wstrb  = {4'b0, n_mem_wstrb};
      o_resp_valid = n_resp_valid;
      o_resp_fault = n_resp_fault;
      o_resp_split = n_resp_split;
    end else if (sel == 2) begin
      o_req_ready  = d_req_ready;
      o_mem_valid  = d_mem_valid;
      o_mem_addr   = d_mem_addr;
      o_mem_wdata  = d_mem_wdata;
      o_mem_wstrb  = d_mem_wstrb;
      o_resp_valid = d_resp_valid;
      o_resp_fault = d_resp_fault;
      o_resp_split = d_resp_split;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: place each store byte individually into its beat and lane.
  task automatic modelStore(input int s, input logic [2:0] f3, input logic amo,
                            input logic [63:0] addr_in, input logic [63:0] data_in);
    int          xlen, nb, size, offset, p;
    logic [63:0] amask, addr, data, base;
    logic        misaligned, illegal;
    xlen  = (s == 2) ? 64 : 32;
    nb    = xlen / 8;
    amask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    addr  = addr_in & amask;
    data  = data_in & amask;
    if (amo) size = (xlen == 64 && f3[1:0] == 2'b11) ? 8 : 4;
    else     size = 1 << f3[1:0];
    illegal    = (size == 8) && (xlen == 32);
    offset     = int'(addr % 64'(nb));
    misaligned = (addr % 64'(size)) != 0;
    exp_fault  = illegal || (misaligned && (amo || s == 1));
    exp_beats  = 0;
    for (int b = 0; b < 2; b++) begin
      exp_addr[b] = '0; exp_wdata[b] = '0; exp_wstrb[b] = '0;
    end
    if (!exp_fault) begin
      base        = addr - 64'(offset);
      exp_addr[0] = base & amask;
      exp_addr[1] = (base + 64'(nb)) & amask;
      for (int k = 0; k < size; k++) begin
        p = offset + k;
        exp_wdata[p / nb] |= ((data >> (8 * k)) & 64'hFF) << (8 * (p % nb));
        exp_wstrb[p / nb] |= 8'(1 << (p % nb));
      end
      exp_beats = (offset + size > nb) ? 2 : 1;
    end
  endtask

  task automatic applyStimulus(input int s, input logic [2:0] f3, input logic amo,
                               input logic [63:0] addr, input logic [63:0] data,
                               input int stall, input string tag);
    int   cyc, waited, nbeat, exp_cyc;
    logic in_beat, unstable, got_resp, zero_strb;
    modelStore(s, f3, amo, addr, data);
    @(negedge clk);
    sel = s; req_funct3 = f3; req_amo = amo; req_addr = addr; req_wdata = data;
    req_valid = 1'b1; mem_ready = 1'b0;
    #1;
    checkOutput({tag, ".req_ready"}, 64'(o_req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; nbeat = 0; waited = 0;
    in_beat = 1'b0; unstable = 1'b0; got_resp = 1'b0; zero_strb = 1'b0;
    first_valid_cyc = -1; obs_fault = 1'b0; obs_split = 1'b0; obs_resp_cyc = -1;
    for (int b = 0; b < 2; b++) begin
      obs_addr[b] = '0; obs_wdata[b] = '0; obs_wstrb[b] = '0;
    end
    while (!got_resp && cyc < 200) begin
      mem_ready = 1'b0;
      if (o_resp_valid) begin
        got_resp     = 1'b1;
        obs_fault    = o_resp_fault;
        obs_split    = o_resp_split;
        obs_resp_cyc = cyc;
      end else if (o_mem_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (o_mem_wstrb == 8'h00) zero_strb = 1'b1;
        if (!in_beat) begin
          in_beat = 1'b1;
          waited  = 0;
          if (nbeat < 2) begin
            obs_addr[nbeat] = o_mem_addr; obs_wdata[nbeat] = o_mem_wdata; obs_wstrb[nbeat] = o_mem_wstrb;
          end
        end else if (nbeat < 2 && (o_mem_addr !== obs_addr[nbeat] ||
                     o_mem_wdata !== obs_wdata[nbeat] || o_mem_wstrb !== obs_wstrb[nbeat])) begin
          unstable = 1'b1;
        end
        if (waited >= stall) begin
          mem_ready = 1'b1;
          in_beat   = 1'b0;
          nbeat++;
        end else begin
          waited++;
        end
      end
      if (!got_resp) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ready = 1'b0;
    checkOutput({tag, ".resp_seen"}, 64'(got_resp), 64'd1);
    checkOutput({tag, ".fault"}, 64'(obs_fault), 64'(exp_fault));
    checkOutput({tag, ".split"}, 64'(obs_split), 64'(exp_beats == 2));
    checkOutput({tag, ".beats"}, 64'(nbeat), 64'(exp_beats));
    for (int b = 0; b < exp_beats; b++) begin
      checkOutput($sformatf("%s.beat%0d_addr", tag, b), obs_addr[b], exp_addr[b]);
      checkOutput($sformatf("%s.beat%0d_wdata", tag, b), obs_wdata[b], exp_wdata[b]);
      checkOutput($sformatf("%s.beat%0d_wstrb", tag, b), 64'(obs_wstrb[b]), 64'(exp_wstrb[b]));
    end
    checkOutput({tag, ".stable"}, 64'(unstable), 64'd0);
    checkOutput({tag, ".nonzero_strb"}, 64'(zero_strb), 64'd0);
    exp_cyc = exp_fault ? 1 : 1 + exp_beats * (stall + 1);
    checkOutput({tag, ".latency"}, 64'(obs_resp_cyc), 64'(exp_cyc));
    if (!exp_fault) checkOutput({tag, ".first_valid"}, 64'(first_valid_cyc), 64'd1);
    @(negedge clk);
    checkOutput({tag, ".resp_pulse"}, 64'(o_resp_valid), 64'd0);
    checkOutput({tag, ".ready_after"}, 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; sel = 0; req_valid = 1'b0; req_amo = 1'b0; mem_ready = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("reset%0d.req_ready", s), 64'(o_req_ready), 64'd0);
      checkOutput($sformatf("reset%0d.mem_valid", s), 64'(o_mem_valid), 64'd0);
      checkOutput($sformatf("reset%0d.mem_addr", s), o_mem_addr, 64'd0);
      checkOutput($sformatf("reset%0d.mem_wstrb", s), 64'(o_mem_wstrb), 64'd0);
      checkOutput($sformatf("reset%0d.resp_valid", s), 64'(o_resp_valid), 64'd0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.ready_on_release", 64'(o_req_ready), 64'd1);

    applyStimulus(0, 3'b000, 1'b0, 64'h4002, 64'h5A, 0, "sb");
    checkOutput("sb.addr_k", obs_addr[0], 64'h4000);
    checkOutput("sb.wstrb_k", 64'(obs_wstrb[0]), 64'h4);
    checkOutput("sb.wdata_k", obs_wdata[0], 64'h005A_0000);

    applyStimulus(0, 3'b001, 1'b0, 64'h1003, 64'hABCD, 0, "sh");
    checkOutput("sh.b0_k", {obs_addr[0][31:0], obs_wdata[0][31:0]}, {32'h1000, 32'hCD00_0000});
    checkOutput("sh.b1_k", {obs_addr[1][31:0], obs_wdata[1][31:0]}, {32'h1004, 32'h0000_00AB});
    checkOutput("sh.strb_k", {obs_wstrb[0], obs_wstrb[1]}, 64'h0801);

    applyStimulus(0, 3'b010, 1'b0, 64'h2002, 64'h1122_3344, 3, "sw_stall");
    checkOutput("sw.b0_k", {obs_addr[0][31:0], obs_wdata[0][31:0]}, {32'h2000, 32'h3344_0000});
    checkOutput("sw.b1_k", {obs_addr[1][31:0], obs_wdata[1][31:0]}, {32'h2004, 32'h0000_1122});
    checkOutput("sw.strb_k", {obs_wstrb[0], obs_wstrb[1]}, 64'h0C03);

    applyStimulus(0, 3'b010, 1'b1, 64'h3001, 64'hDEAD_BEEF, 0, "amo_mis");
    checkOutput("amo.fault_k", 64'(obs_fault), 64'd1);
    applyStimulus(1, 3'b010, 1'b0, 64'h2002, 64'h1122_3344, 0, "nosplit_sw");
    checkOutput("nosplit.fault_k", 64'(obs_fault), 64'd1);

    applyStimulus(2, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0102_0304_0506_0708, 0, "sd_wrap");
    checkOutput("sd.b0_addr_k", obs_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
    checkOutput("sd.b1_addr_k", obs_addr[1], 64'h0);
    checkOutput("sd.b1_wstrb_k", 64'(obs_wstrb[1]), 64'h0F);
    applyStimulus(0, 3'b011, 1'b0, 64'h100, 64'h1234, 0, "sd_rv32");
    checkOutput("sd_rv32.fault_k", 64'(obs_fault), 64'd1);

    // Reset while the second beat of a split store is stalled.
    @(negedge clk);
    sel = 0; req_funct3 = 3'b001; req_amo = 1'b0; req_addr = 64'h1003; req_wdata = 64'hABCD;
    req_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checkOutput("rst.in_beat1", 64'(o_mem_valid), 64'd1);
    checkOutput("rst.beat1_addr", o_mem_addr, 64'h1004);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst.mem_valid", 64'(o_mem_valid), 64'd0);
    checkOutput("rst.resp_valid", 64'(o_resp_valid), 64'd0);
    checkOutput("rst.req_ready", 64'(o_req_ready), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst.ready_release", 64'(o_req_ready), 64'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_resp_valid || o_mem_valid) seen = 1'b1;
    end
    checkOutput("rst.no_resp", 64'(seen), 64'd0);

    for (int s = 0; s < 3; s++) begin
      for (int t = 0; t < 30; t++) begin
        applyStimulus(s, {1'b0, 2'($urandom_range(0, 3))}, ($urandom_range(0, 7) == 0),
                      {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 2)),
                      $sformatf("rnd%0d_%0d", s, t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_split_unit.md
STORE_SPLIT_UNIT -- requirements
Module: store_split_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, data/address width; legal values are 32 or 64.
REQ-002 SHALL have parameter ALLOW_SPLIT, 1, where 1 splits misaligned non-AMO stores into two beats and 0 faults them.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  store request.
- req_ready  output  1  unit can accept a request.
- req_funct3  input  3  store funct3.
- req_amo  input  1  AMO store; forces word size, or doubleword when funct3=011 and XLEN=64.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- mem_valid  output  1  bus beat valid.
- mem_ready  input  1  bus beat accepted.
- mem_addr  output  XLEN  NB-aligned beat address, where NB=XLEN/8.
- mem_wdata  output  XLEN  lane-positioned data.
- mem_wstrb  output  NB  byte strobes.
- resp_valid  output  1  one-cycle completion pulse.
- resp_fault  output  1  misaligned or illegal store; valid with resp_valid.
- resp_split  output  1  store used two beats; valid with resp_valid.

Function
REQ-005 SHALL decode size from funct3[1:0]:
- 00=B, 01=H, 10=W, 11=D.
- D is illegal when XLEN=32 and SHALL fault.
REQ-006 SHALL define offset = addr mod NB and misaligned = addr mod size != 0.
REQ-007 SHALL build a 2*XLEN lane image = (wdata masked to size) << (8*offset) and a 2*NB strobe image = size-ones << offset.
REQ-008 SHALL use FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-009 SHALL assert req_ready only in IDLE with rst low; a request is accepted on req_valid&&req_ready, and all request fields are captured that cycle.
REQ-010 SHALL, on accept, go to RESP with resp_fault=1 and no bus traffic if any of these hold:
- the size is illegal;
- AMO and misaligned;
- ALLOW_SPLIT=0 and misaligned.
Otherwise it goes to BEAT0.
REQ-011 SHALL in BEAT0 drive:
- mem_valid=1;
- mem_addr = addr with low log2(NB) bits cleared;
- the low halves of the lane and strobe images.
REQ-012 SHALL, on a BEAT0 handshake, go to BEAT1 if the upper strobe half is nonzero, else RESP.
REQ-013 SHALL in BEAT1 drive mem_addr = BEAT0 address + NB (wrapping modulo 2^XLEN) with the upper image halves, and go to RESP on handshake.
REQ-014 SHALL hold mem_addr, mem_wdata and mem_wstrb stable while mem_valid=1 and mem_ready=0; mem_valid SHALL NOT drop before the handshake.
REQ-015 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE.
REQ-016 SHALL set resp_split=1 iff BEAT1 was executed for that request.
REQ-017 SHALL drive mem_wdata and mem_wstrb to zero whenever mem_valid=0.
REQ-018 SHALL give an aligned store with zero-wait memory: accept at cycle T, mem_valid at T+1, resp_valid at T+2; a split store adds one cycle.
REQ-019 SHALL never emit a beat with mem_wstrb=0.
REQ-020 SHALL allow only one request in flight; there is no pipelining.

Reset
REQ-021 SHALL, while rst=1, force state IDLE and drive req_ready, mem_valid, mem_wdata, mem_wstrb, resp_valid, resp_fault and resp_split to 0, and mem_addr to 0.
REQ-022 SHALL, on rst asserted in BEAT0/BEAT1/RESP, abandon the transaction with no resp_valid, and drop mem_valid the cycle after the reset edge.
REQ-023 SHALL assert req_ready in the first cycle after rst deasserts.

Structure
REQ-024 SHALL place these in riscv_defines-style shared package store_pkg:
- the size enum (B/H/W/D);
- the FSM state enum;
- the size-to-bytemask function.
REQ-025 SHALL put lane-image and strobe-image generation in one combinational sub-module, store_lane_gen, parametrised by XLEN; the FSM and capture registers stay in store_split_unit.

Verification (XLEN=32 unless noted)
REQ-026 SHALL cover: SB 0x4002, data 0x5A -> one beat addr 0x4000, wstrb 0100, wdata 0x005A0000, resp_split=0.
REQ-027 SHALL cover: SH 0x1003, data 0xABCD -> beat0 0x1000/1000/0xCD000000, beat1 0x1004/0001/0x000000AB, resp_split=1.
REQ-028 SHALL cover: SW 0x2002, data 0x11223344, mem_ready low 3 cycles per beat -> beat0 0x2000/1100/0x33440000 held stable, beat1 0x2004/0011/0x00001122.
REQ-029 SHALL cover: AMO 0x3001, and (ALLOW_SPLIT=0) SW 0x2002 -> resp_fault=1 at T+1, mem_valid never asserted.
REQ-030 SHALL cover: XLEN=64, SD 0xFFFF_FFFF_FFFF_FFFC -> beat1 address wraps to 0x0, wstrb 00001111; XLEN=32 funct3=011 -> fault.
REQ-031 SHALL cover: rst pulse during BEAT1 stall -> mem_valid 0 the next cycle, no resp_valid, req_ready=1 after release.
